// File: rtl/axi_lite_cmd_master.sv
// AXI-lite command master: turns single-cycle read/write commands into AR/R or
// AW/W handshakes with a per-phase timeout. Every output is driven from a register.
module axi_lite_cmd_master #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              m_arvalid,
  output logic [ADDR_W-1:0] m_araddr,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              m_rready,
  output logic              m_awvalid,
  output logic [ADDR_W-1:0] m_awaddr,
  input  logic              m_awready,
  output logic              m_wvalid,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_wready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, RESP} state_t;

  state_t              state, state_n;
  logic [7:0]          cnt, cnt_n, cnt_inc;
  logic                timeout_hit;
  logic                aw_done, aw_done_n, w_done, w_done_n;
  logic                aw_hs, w_hs;

  logic                cmd_ready_n;
  logic                arvalid_n, rready_n, awvalid_n, wvalid_n;
  logic [ADDR_W-1:0]   araddr_n, awaddr_n;
  logic [DATA_W-1:0]   wdata_n, rsp_data_n;
  logic                rsp_valid_n, rsp_err_n;

  assign cnt_inc     = cnt + 8'd1;
  assign timeout_hit = (cnt_inc == TO_LIMIT);

  // Outputs are computed one cycle ahead and registered, so every branch below
  // describes what the bus sees in the following cycle.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    aw_done_n   = aw_done;
    w_done_n    = w_done;
    cmd_ready_n = 1'b0;
    arvalid_n   = m_arvalid;
    araddr_n    = m_araddr;
    rready_n    = m_rready;
    awvalid_n   = m_awvalid;
    awaddr_n    = m_awaddr;
    wvalid_n    = m_wvalid;
    wdata_n     = m_wdata;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data;
    rsp_err_n   = rsp_err;
    aw_hs       = m_awvalid && m_awready;
    w_hs        = m_wvalid && m_wready;

    unique case (state)
      IDLE: begin
        cnt_n       = '0;
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_n = 1'b0;
          if (cmd_write) begin
            awaddr_n  = cmd_addr;
            wdata_n   = cmd_wdata;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
            state_n   = WR;
          end else begin
            araddr_n  = cmd_addr;
            arvalid_n = 1'b1;
            state_n   = RD_ADDR;
          end
        end
      end

      RD_ADDR: begin
        if (m_arvalid && m_arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          cnt_n     = '0;
          state_n   = RD_DATA;
        end else if (timeout_hit) begin
          arvalid_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_data_n  = '0;
          state_n     = RESP;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      RD_DATA: begin
        if (m_rvalid && m_rready) begin
          rready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          rsp_data_n  = m_rdata;
          state_n     = RESP;
        end else if (timeout_hit) begin
          rready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_data_n  = '0;
          state_n     = RESP;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      WR: begin
        aw_done_n = aw_done || aw_hs;
        w_done_n  = w_done || w_hs;
        awvalid_n = m_awvalid && !aw_hs;
        wvalid_n  = m_wvalid && !w_hs;
        if (aw_done_n && w_done_n) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          rsp_data_n  = '0;
          state_n     = RESP;
        end else if (timeout_hit) begin
          awvalid_n   = 1'b0;
          wvalid_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_data_n  = '0;
          state_n     = RESP;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      RESP: begin
        cnt_n       = '0;
        cmd_ready_n = 1'b1;
        state_n     = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      cmd_ready <= 1'b0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_rready  <= 1'b0;
      m_awvalid <= 1'b0;
      m_awaddr  <= '0;
      m_wvalid  <= 1'b0;
      m_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      aw_done   <= aw_done_n;
      w_done    <= w_done_n;
      cmd_ready <= cmd_ready_n;
      m_arvalid <= arvalid_n;
      m_araddr  <= araddr_n;
      m_rready  <= rready_n;
      m_awvalid <= awvalid_n;
      m_awaddr  <= awaddr_n;
      m_wvalid  <= wvalid_n;
      m_wdata   <= wdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
      rsp_err   <= rsp_err_n;
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: a per-cycle slave with programmable ready delays
// and an arithmetic model of phase lengths, latency and response contents.
module tb_axi_lite_cmd_master;

  localparam int AW = 4;
  localparam int DW = 4;
  localparam int T  = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0] m_araddr, m_awaddr;
  logic [DW-1:0] m_rdata, m_wdata, rsp_data;
  logic          m_awvalid, m_awready, m_wvalid, m_wready;
  logic          rsp_valid, rsp_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_lite_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wready(m_wready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  typedef struct {
    int            lat;
    int            ar_n, r_n, aw_n, w_n, rsp_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] data;
    logic          err, unstable, ready_after;
  } obs_t;

  typedef struct {
    int            lat;
    int            ar_n, r_n, aw_n, w_n;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  // A phase that needs d wait cycles finishes in cycle d+1 unless d+1 exceeds T,
  // in which case it is cut off after T cycles; RESP follows one cycle later.
  function automatic exp_t model(input logic wr, input logic [DW-1:0] rdata,
                                 input int d_ar, input int d_r, input int d_aw, input int d_w);
    exp_t e;
    int   ph;
    e = '{default: 0};
    if (wr) begin
      e.aw_n = (d_aw + 1 > T) ? T : d_aw + 1;
      e.w_n  = (d_w + 1 > T) ? T : d_w + 1;
      ph     = ((d_aw > d_w) ? d_aw : d_w) + 1;
      e.err  = (ph > T);
      e.lat  = ((ph > T) ? T : ph) + 1;
    end else begin
      e.ar_n = (d_ar + 1 > T) ? T : d_ar + 1;
      if (d_ar + 1 > T) begin
        e.err = 1'b1;
        e.lat = T + 1;
      end else begin
        e.r_n  = (d_r + 1 > T) ? T : d_r + 1;
        e.err  = (d_r + 1 > T);
        e.lat  = e.ar_n + e.r_n + 1;
        e.data = e.err ? '0 : rdata;
      end
    end
    return e;
  endfunction

  task automatic clear_slave();
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    m_awready = 1'b0; m_wready = 1'b0;
  endtask

  // Issues one command and plays the slave; each ready/rvalid rises once its
  // valid/rready has been high for d cycles. hold keeps cmd_valid asserted with
  // different fields while the command is in flight.
  task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] rdata, input int d_ar, input int d_r,
                        input int d_aw, input int d_w, input logic hold, output obs_t o);
    int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, waitc = 0;
    bit a_set = 0, d_set = 0;
    o = '{default: 0};
    o.lat = -1;
    @(negedge clk);
    while (!cmd_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_ready_wait got=%b exp=1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (hold) begin
        cmd_addr = ~addr; cmd_wdata = ~wdata; cmd_write = ~wr;
      end else begin
        cmd_valid = 1'b0;
      end
      if (m_arvalid) begin
        o.ar_n++;
        if (!a_set) begin o.addr = m_araddr; a_set = 1; end
        else if (m_araddr !== o.addr) o.unstable = 1'b1;
      end
      if (m_awvalid) begin
        o.aw_n++;
        if (!a_set) begin o.addr = m_awaddr; a_set = 1; end
        else if (m_awaddr !== o.addr) o.unstable = 1'b1;
      end
      if (m_wvalid) begin
        o.w_n++;
        if (!d_set) begin o.wdata = m_wdata; d_set = 1; end
        else if (m_wdata !== o.wdata) o.unstable = 1'b1;
      end
      if (m_rready) o.r_n++;
      if (rsp_valid) begin
        o.rsp_n++;
        o.lat  = c;
        o.data = rsp_data;
        o.err  = rsp_err;
        cmd_valid = 1'b0;
        break;
      end
      m_arready = m_arvalid && (ar_c >= d_ar);
      if (m_arvalid) ar_c++;
      m_awready = m_awvalid && (aw_c >= d_aw);
      if (m_awvalid) aw_c++;
      m_wready = m_wvalid && (w_c >= d_w);
      if (m_wvalid) w_c++;
      m_rvalid = m_rready && (r_c >= d_r);
      m_rdata  = m_rvalid ? rdata : DW'($urandom);
      if (m_rready) r_c++;
    end
    clear_slave();
    cmd_valid = 1'b0;
    @(negedge clk);
    o.ready_after = cmd_ready;
    if (rsp_valid) o.rsp_n++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, m_arvalid, m_rready, m_awvalid, m_wvalid, rsp_valid, rsp_err} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {cmd_ready, m_arvalid, m_rready, m_awvalid, m_wvalid, rsp_valid, rsp_err});
    end
    checks++;
    if ({m_araddr, m_awaddr, m_wdata, rsp_data} !== 16'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0000", {m_araddr, m_awaddr, m_wdata, rsp_data});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_read_basic();
    obs_t o;
    do_txn(1'b0, 4'h3, 4'h0, 4'h9, 0, 0, 0, 0, 1'b0, o);
    checks++; if (o.lat !== 3) begin failures++; $display("FAIL rd_lat got=%0d exp=3", o.lat); end
    checks++; if (o.ar_n !== 1) begin failures++; $display("FAIL rd_arvalid_cycles got=%0d exp=1", o.ar_n); end
    checks++; if (o.r_n !== 1) begin failures++; $display("FAIL rd_rready_cycles got=%0d exp=1", o.r_n); end
    checks++; if (o.addr !== 4'h3) begin failures++; $display("FAIL rd_araddr got=%h exp=3", o.addr); end
    checks++; if (o.data !== 4'h9) begin failures++; $display("FAIL rd_data got=%h exp=9", o.data); end
    checks++; if (o.err !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", o.err); end
    checks++; if (o.ready_after !== 1'b1) begin failures++; $display("FAIL rd_ready_after got=%b exp=1", o.ready_after); end
  endtask

  task automatic test_write_basic();
    obs_t o;
    do_txn(1'b1, 4'h3, 4'h4, 4'h0, 0, 0, 0, 0, 1'b0, o);
    checks++; if (o.lat !== 2) begin failures++; $display("FAIL wr_lat got=%0d exp=2", o.lat); end
    checks++; if (o.aw_n !== 1 || o.w_n !== 1) begin failures++; $display("FAIL wr_valid_cycles got=%0d/%0d exp=1/1", o.aw_n, o.w_n); end
    checks++; if (o.addr !== 4'h3 || o.wdata !== 4'h4) begin failures++; $display("FAIL wr_addr_data got=%h/%h exp=3/4", o.addr, o.wdata); end
    checks++; if (o.err !== 1'b0 || o.data !== 4'h0) begin failures++; $display("FAIL wr_rsp got=%b/%h exp=0/0", o.err, o.data); end
    checks++; if (o.rsp_n !== 1) begin failures++; $display("FAIL wr_rsp_count got=%0d exp=1", o.rsp_n); end
  endtask

  task automatic test_write_w_late();
    obs_t o;
    do_txn(1'b1, 4'h7, 4'hC, 4'h0, 0, 0, 0, 3, 1'b0, o);
    checks++; if (o.aw_n !== 1) begin failures++; $display("FAIL wlate_awvalid_cycles got=%0d exp=1", o.aw_n); end
    checks++; if (o.w_n !== 4) begin failures++; $display("FAIL wlate_wvalid_cycles got=%0d exp=4", o.w_n); end
    checks++; if (o.lat !== 5) begin failures++; $display("FAIL wlate_lat got=%0d exp=5", o.lat); end
    checks++; if (o.rsp_n !== 1 || o.unstable !== 1'b0) begin failures++; $display("FAIL wlate_rsp_stable got=%0d/%b exp=1/0", o.rsp_n, o.unstable); end
  endtask

  task automatic test_busy_ignored();
    obs_t o;
    do_txn(1'b0, 4'h6, 4'h0, 4'hA, 2, 1, 0, 0, 1'b1, o);
    checks++; if (o.addr !== 4'h6 || o.unstable !== 1'b0) begin failures++; $display("FAIL busy_araddr got=%h/%b exp=6/0", o.addr, o.unstable); end
    checks++; if (o.aw_n !== 0 || o.w_n !== 0) begin failures++; $display("FAIL busy_no_write got=%0d/%0d exp=0/0", o.aw_n, o.w_n); end
    checks++; if (o.rsp_n !== 1 || o.data !== 4'hA) begin failures++; $display("FAIL busy_rsp got=%0d/%h exp=1/a", o.rsp_n, o.data); end
    checks++; if (o.lat !== 6) begin failures++; $display("FAIL busy_lat got=%0d exp=6", o.lat); end
  endtask

  task automatic test_read_timeout();
    obs_t o;
    do_txn(1'b0, 4'h2, 4'h0, 4'h5, 255, 0, 0, 0, 1'b0, o);
    checks++; if (o.ar_n !== T) begin failures++; $display("FAIL to_arvalid_cycles got=%0d exp=%0d", o.ar_n, T); end
    checks++; if (o.r_n !== 0) begin failures++; $display("FAIL to_rready_cycles got=%0d exp=0", o.r_n); end
    checks++; if (o.lat !== T + 1) begin failures++; $display("FAIL to_lat got=%0d exp=%0d", o.lat, T + 1); end
    checks++; if (o.err !== 1'b1 || o.data !== 4'h0) begin failures++; $display("FAIL to_rsp got=%b/%h exp=1/0", o.err, o.data); end
    checks++; if (o.ready_after !== 1'b1) begin failures++; $display("FAIL to_ready_after got=%b exp=1", o.ready_after); end
  endtask

  task automatic test_timeout_boundary();
    int   tbl[4][5] = '{'{0, T - 1, 0, 0, 0}, '{0, 0, T, 0, 0},
                        '{1, 0, 0, T - 1, 2}, '{1, 0, 0, T, 0}};
    obs_t o;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e = model(tbl[i][0] != 0, 4'hB, tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4]);
      do_txn(tbl[i][0] != 0, 4'h1, 4'h2, 4'hB, tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], 1'b0, o);
      checks++; if (o.err !== e.err || o.lat !== e.lat) begin failures++; $display("FAIL bound%0d_err_lat got=%b/%0d exp=%b/%0d", i, o.err, o.lat, e.err, e.lat); end
      checks++; if ({o.ar_n, o.r_n, o.aw_n, o.w_n} !== {e.ar_n, e.r_n, e.aw_n, e.w_n}) begin failures++; $display("FAIL bound%0d_cycles got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", i, o.ar_n, o.r_n, o.aw_n, o.w_n, e.ar_n, e.r_n, e.aw_n, e.w_n); end
      checks++; if (o.data !== e.data) begin failures++; $display("FAIL bound%0d_data got=%h exp=%h", i, o.data, e.data); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   n_rsp = 0, waitc = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h5;
    m_arready = 1'b1; m_rvalid = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!m_rready && waitc < 10) begin @(negedge clk); waitc++; end
    checks++; if (m_rready !== 1'b1) begin failures++; $display("FAIL rstmid_reach_rd_data got=%b exp=1", m_rready); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, m_arvalid, m_rready, m_awvalid, m_wvalid, rsp_valid, rsp_err, m_araddr, rsp_data} !== 15'h0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%h exp=0000",
               {cmd_ready, m_arvalid, m_rready, m_awvalid, m_wvalid, rsp_valid, rsp_err, m_araddr, rsp_data});
    end
    rst = 1'b0;
    clear_slave();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    checks++; if (n_rsp !== 0) begin failures++; $display("FAIL rstmid_no_rsp got=%0d exp=0", n_rsp); end
    do_txn(1'b0, 4'hE, 4'h0, 4'h7, 0, 0, 0, 0, 1'b0, o);
    checks++; if (o.lat !== 3 || o.data !== 4'h7 || o.err !== 1'b0) begin failures++; $display("FAIL rstmid_next got=%0d/%h/%b exp=3/7/0", o.lat, o.data, o.err); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    int   d[4];
    logic wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: d[k] = 0;
          4, 5:       d[k] = int'($urandom_range(1, 3));
          6:          d[k] = T - 1;
          7:          d[k] = T;
          8:          d[k] = 255;
          default:    d[k] = int'($urandom_range(0, T + 3));
        endcase
      end
      wr = 1'($urandom);
      a  = AW'($urandom);
      wd = DW'($urandom);
      rd = DW'($urandom);
      e  = model(wr, rd, d[0], d[1], d[2], d[3]);
      do_txn(wr, a, wd, rd, d[0], d[1], d[2], d[3], 1'b0, o);
      checks++; if (o.lat !== e.lat || o.err !== e.err) begin failures++; $display("FAIL rnd%0d_lat_err got=%0d/%b exp=%0d/%b", i, o.lat, o.err, e.lat, e.err); end
      checks++; if (o.data !== e.data) begin failures++; $display("FAIL rnd%0d_data got=%h exp=%h", i, o.data, e.data); end
      checks++; if ({o.ar_n, o.r_n, o.aw_n, o.w_n} !== {e.ar_n, e.r_n, e.aw_n, e.w_n}) begin failures++; $display("FAIL rnd%0d_cycles got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", i, o.ar_n, o.r_n, o.aw_n, o.w_n, e.ar_n, e.r_n, e.aw_n, e.w_n); end
      checks++; if (o.addr !== a || o.unstable !== 1'b0 || (wr && o.wdata !== wd)) begin failures++; $display("FAIL rnd%0d_addr got=%h/%h/%b exp=%h/%h/0", i, o.addr, o.wdata, o.unstable, a, wd); end
      checks++; if (o.rsp_n !== 1 || o.ready_after !== 1'b1) begin failures++; $display("FAIL rnd%0d_rsp_once got=%0d/%b exp=1/1", i, o.rsp_n, o.ready_after); end
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    clear_slave();
    test_reset();
    test_read_basic();
    test_write_basic();
    test_write_w_late();
    test_busy_ignored();
    test_read_timeout();
    test_timeout_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
Upstream AXI-lite master stage that feeds the 4-bit register-file slave (tt_um_thejesvinii_axi). It converts single-cycle read/write commands from the switch/button front-end into compliant AR/R and AW/W handshakes, with independent AW/W completion and a per-phase timeout. It returns the read data or a completion/error status to the front-end. There is no B channel; a write completes when both AW and W handshakes are done.

Parameters:
ADDR_W, 4, address width
DATA_W, 4, data width
TIMEOUT, 15, max wait cycles per handshake phase before abort (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid&&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
m_arvalid  out  1  read address valid
m_araddr  out  ADDR_W  read address
m_arready  in  1  slave read address ready
m_rvalid  in  1  slave read data valid
m_rdata  in  DATA_W  slave read data
m_rready  out  1  read data ready
m_awvalid  out  1  write address valid
m_awaddr  out  ADDR_W  write address
m_awready  in  1  slave write address ready
m_wvalid  out  1  write data valid
m_wdata  out  DATA_W  write data
m_wready  in  1  slave write data ready
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  DATA_W  captured read data (0 for writes/errors)
rsp_err  out  1  timeout flag, valid with rsp_valid

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Every output is registered.
- Reset: all outputs 0 (including cmd_ready). FSM goes to IDLE and the timeout counter clears. Reset asserted mid-transaction drops all valids at that edge; no rsp_valid is issued for the aborted command.
- States: IDLE, RD_ADDR, RD_DATA, WR, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch addr/wdata/write into registers.
  - Read accepted -> RD_ADDR; write accepted -> WR.
  - Counter cleared.
- RD_ADDR:
  - m_arvalid=1, m_araddr stable.
  - On m_arvalid&&m_arready -> RD_DATA; arvalid low from next cycle.
- RD_DATA:
  - m_rready=1.
  - On m_rvalid&&m_rready, capture m_rdata into rsp_data -> RESP.
- WR:
  - m_awvalid and m_wvalid both assert on entry.
  - Each deasserts the cycle after its own handshake; a done flag is kept per channel.
  - Simultaneous AW and W handshake in one cycle completes both.
  - When both done -> RESP.
  - m_awaddr and m_wdata are held stable throughout WR.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - cmd_ready returns to 1 the cycle after RESP.
- Valid persistence: once asserted, a valid is held until its handshake; the only exception is a timeout abort.
- Timeout:
  - The counter restarts on entry to RD_ADDR, RD_DATA and WR, and increments each cycle the phase remains incomplete.
  - When it reaches TIMEOUT, drop all valids/rready, set rsp_err=1, rsp_data=0 -> RESP.
  - A handshake occurring in the same cycle the counter hits TIMEOUT wins: it completes normally, with no error.
- Latency with an always-ready slave (accept at edge N):
  - Read: arvalid high cycle N+1, rready high cycle N+2, rsp_valid in cycle N+3.
  - Write: aw/wvalid high cycle N+1, rsp_valid in cycle N+2.
- cmd_valid while busy is ignored (cmd_ready=0); no queueing.
- rsp_data/rsp_err hold their values until the next RESP.

Test Plan:
- Read, always-ready slave returning 4'h9 at addr 3: accept at edge N -> m_araddr=3, arvalid for 1 cycle, rready for 1 cycle, rsp_valid in cycle N+3 with rsp_data=9, rsp_err=0.
- Write addr 3 data 4, awready/wready both high -> awvalid and wvalid high for 1 cycle, m_awaddr=3, m_wdata=4; rsp_valid in cycle N+2, rsp_err=0.
- Write with awready immediate, wready 3 cycles late -> awvalid drops after 1 cycle, wvalid held 4 cycles, single rsp_valid after the W handshake.
- Read with arready tied 0, TIMEOUT=15 -> arvalid high exactly 15 cycles then low, rsp_valid with rsp_err=1, rsp_data=0, cmd_ready=1 next cycle.
- cmd_valid held high during a pending read with a different address -> ignored; m_araddr unchanged; exactly one rsp_valid.
- rst pulsed while in RD_DATA -> all outputs 0 on that edge, no rsp_valid, next command executes normally.
